// File: rtl/mini_pkg.sv
// Shared definitions for the mini ALU: op codes, FSM state encoding and default data width.
package mini_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mul8_seq.sv
// Sequential shift-add multiplier: one partial product per step, WIDTH steps per product.
// 'product' is the running sum including the current step's partial product, so the
// owner can capture the finished result on the same edge as the final step.
module mul8_seq
  import mini_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] addend;

  // Partial product: the shifted multiplicand gated by the current multiplier LSB
  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
  end

  assign product = acc_reg + addend;
  assign cnt     = cnt_reg;

  // Load operands on start, then accumulate one multiplier bit per step
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, mcand};
      mplier_reg <= mplier;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (step) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mini_alu.sv
// Accumulator ALU: LOAD/ADD/SUB complete in one execute cycle, MUL runs the
// sequential multiplier for WIDTH cycles. All outputs are registered.
module mini_alu
  import mini_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] ALUOut,
  output logic             add,
  output logic             sub,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg;
  op_t                op_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic [WIDTH-1:0]   alu_reg;
  logic               add_reg;
  logic               sub_reg;
  logic               carry_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               mul_start;
  logic               mul_step;
  logic               mul_last;
  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;

  // Multiplier is loaded on the accepting edge with the current accumulator and new operand
  assign mul_start = (state_reg == IDLE) && start && (op_t'(op) == OP_MUL);
  assign mul_step  = (state_reg == MULT);
  assign mul_last  = (mul_cnt == CW'(WIDTH - 1));

  // Extra top bit carries out of ADD and signals borrow for SUB
  assign sum_ext  = {1'b0, alu_reg} + {1'b0, operand_reg};
  assign diff_ext = {1'b0, alu_reg} - {1'b0, operand_reg};

  mul8_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (mul_start),
    .step    (mul_step),
    .mcand   (alu_reg),
    .mplier  (operand),
    .cnt     (mul_cnt),
    .product (mul_product)
  );

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg   <= IDLE;
      op_reg      <= OP_LOAD;
      operand_reg <= '0;
      alu_reg     <= '0;
      add_reg     <= 1'b0;
      sub_reg     <= 1'b0;
      carry_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            op_reg      <= op_t'(op);
            operand_reg <= operand;
            busy_reg    <= 1'b1;
            state_reg   <= (op_t'(op) == OP_MUL) ? MULT : EXEC;
          end
        end
        EXEC: begin
          case (op_reg)
            OP_LOAD: begin
              alu_reg   <= operand_reg;
              carry_reg <= 1'b0;
              add_reg   <= 1'b0;
              sub_reg   <= 1'b0;
            end
            OP_ADD: begin
              alu_reg   <= sum_ext[WIDTH-1:0];
              carry_reg <= sum_ext[WIDTH];
              add_reg   <= 1'b1;
              sub_reg   <= 1'b0;
            end
            OP_SUB: begin
              alu_reg   <= diff_ext[WIDTH-1:0];
              carry_reg <= diff_ext[WIDTH];
              add_reg   <= 1'b0;
              sub_reg   <= 1'b1;
            end
            default: begin
              // MUL never reaches EXEC; keep the accumulator and clear flags
              carry_reg <= 1'b0;
              add_reg   <= 1'b0;
              sub_reg   <= 1'b0;
            end
          endcase
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        MULT: begin
          // Accumulator holds until the last step writes the finished product
          if (mul_last) begin
            alu_reg   <= mul_product[WIDTH-1:0];
            carry_reg <= |mul_product[2*WIDTH-1:WIDTH];
            add_reg   <= 1'b0;
            sub_reg   <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ALUOut, add and sub feed the display stage directly
  assign ALUOut = alu_reg;
  assign add    = add_reg;
  assign sub    = sub_reg;
  assign carry  = carry_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_mini_alu.sv
// Directed self-checking bench for mini_alu (WIDTH=8) with hand-computed expectations.
module tb_mini_alu;
  import mini_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       start;
  logic [1:0] op;
  logic [7:0] operand;
  logic [7:0] ALUOut;
  logic       add;
  logic       sub;
  logic       carry;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  int done_at;

  always #5 CLK = ~CLK;

  mini_alu #(
    .WIDTH (8)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (start),
    .op      (op),
    .operand (operand),
    .ALUOut  (ALUOut),
    .add     (add),
    .sub     (sub),
    .carry   (carry),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one op, check busy/ALUOut hold until done, then latency, results and return to idle
  task automatic run_op(input logic [1:0] o, input logic [7:0] v, input logic [7:0] prev,
                        input int lat, input logic [7:0] e_alu, input logic e_c,
                        input logic e_add, input logic e_sub, input string tag);
    int n;
    op = o;
    operand = v;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      chk1({tag, " busy"}, busy, 1'b1);
      chk8({tag, " hold"}, ALUOut, prev);
      @(negedge CLK);
      n++;
    end
    chki({tag, " latency"}, n, lat);
    chk8({tag, " ALUOut"}, ALUOut, e_alu);
    chk1({tag, " carry"}, carry, e_c);
    chk1({tag, " add"}, add, e_add);
    chk1({tag, " sub"}, sub, e_sub);
    chk1({tag, " busy_done"}, busy, 1'b1);
    @(negedge CLK);
    chk1({tag, " done_pulse"}, done, 1'b0);
    chk1({tag, " busy_idle"}, busy, 1'b0);
    $display("op=%0d operand=0x%02h -> ALUOut=0x%02h carry=%b add=%b sub=%b latency=%0d (%s)",
             o, v, ALUOut, carry, add, sub, n, tag);
  endtask

  initial begin
    RSTn = 1'b0;
    start = 1'b0;
    op = 2'b00;
    operand = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    chk8("reset ALUOut", ALUOut, 8'h00);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset carry", carry, 1'b0);
    chk1("reset add", add, 1'b0);
    chk1("reset sub", sub, 1'b0);
    $display("reset applied: ALUOut=0x%02h busy=%b done=%b", ALUOut, busy, done);
    RSTn = 1'b1;

    run_op(OP_LOAD, 8'h14, 8'h00, 2, 8'h14, 1'b0, 1'b0, 1'b0, "load14");

    run_op(OP_LOAD, 8'hF0, 8'h14, 2, 8'hF0, 1'b0, 1'b0, 1'b0, "loadF0");
    run_op(OP_ADD,  8'h20, 8'hF0, 2, 8'h10, 1'b1, 1'b1, 1'b0, "add_wrap");

    run_op(OP_LOAD, 8'h05, 8'h10, 2, 8'h05, 1'b0, 1'b0, 1'b0, "load05");
    run_op(OP_SUB,  8'h07, 8'h05, 2, 8'hFE, 1'b1, 1'b0, 1'b1, "sub_borrow");
    run_op(OP_SUB,  8'h01, 8'hFE, 2, 8'hFD, 1'b0, 1'b0, 1'b1, "sub_plain");

    run_op(OP_LOAD, 8'h12, 8'hFD, 2, 8'h12, 1'b0, 1'b0, 1'b0, "load12");
    run_op(OP_MUL,  8'h0F, 8'h12, 9, 8'h0E, 1'b1, 1'b0, 1'b0, "mul_ovf");
    run_op(OP_ADD,  8'h01, 8'h0E, 2, 8'h0F, 1'b0, 1'b1, 1'b0, "add_nocarry");

    // start held into EXEC with a different op must be ignored
    op = OP_LOAD;
    operand = 8'h20;
    start = 1'b1;
    @(negedge CLK);
    op = OP_ADD;
    operand = 8'h01;
    @(negedge CLK);
    start = 1'b0;
    chk1("exec_ignore done", done, 1'b1);
    chk8("exec_ignore ALUOut", ALUOut, 8'h20);
    @(negedge CLK);
    chk1("exec_ignore idle", busy, 1'b0);
    chk8("exec_ignore final", ALUOut, 8'h20);
    $display("load 0x20 with start held in EXEC -> ALUOut=0x%02h", ALUOut);

    // start pulsed during MULT (cycle 3) and DONE (cycle 9) must be ignored
    run_op(OP_LOAD, 8'h03, 8'h20, 2, 8'h03, 1'b0, 1'b0, 1'b0, "load03");
    op = OP_MUL;
    operand = 8'h05;
    start = 1'b1;
    @(negedge CLK);
    done_cnt = 0;
    done_at = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      start = (c == 3 || c == 9) ? 1'b1 : 1'b0;
      op = OP_LOAD;
      operand = 8'hAA;
      @(negedge CLK);
    end
    chki("ignore done_count", done_cnt, 1);
    chki("ignore done_cycle", done_at, 9);
    chk8("ignore ALUOut", ALUOut, 8'h0F);
    chk1("ignore carry", carry, 1'b0);
    chk1("ignore busy", busy, 1'b0);
    $display("mul 0x03*0x05 with stray starts -> ALUOut=0x%02h done_pulses=%0d", ALUOut, done_cnt);

    // reset mid-MULT aborts with no done; reset dominates start
    op = OP_MUL;
    operand = 8'h03;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk1("midmul busy", busy, 1'b1);
    RSTn = 1'b0;
    start = 1'b1;
    op = OP_LOAD;
    operand = 8'h55;
    @(negedge CLK);
    chk8("abort ALUOut", ALUOut, 8'h00);
    chk1("abort busy", busy, 1'b0);
    chk1("abort done", done, 1'b0);
    chk1("abort carry", carry, 1'b0);
    @(negedge CLK);
    chk1("rst_vs_start busy", busy, 1'b0);
    chk1("rst_vs_start done", done, 1'b0);
    chk8("rst_vs_start ALUOut", ALUOut, 8'h00);
    $display("reset mid-MULT -> ALUOut=0x%02h busy=%b done=%b", ALUOut, busy, done);
    RSTn = 1'b1;
    run_op(OP_LOAD, 8'h07, 8'h00, 2, 8'h07, 1'b0, 1'b0, 1'b0, "load07_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
